muldiv_seq: RTL and testbench

- Iterative RV32M multiply/divide sequencer beside the single-cycle ALU in the execute stage.
- Accepts one M-extension op from execute and stalls the pipeline while it iterates (1 bit per cycle, 32 iterations).
- Presents a 32-bit result aligned with a one-cycle done pulse.
- Owns its own adder/subtractor and shift registers; the ALU stays free of multi-cycle logic.

---
 rtl/muldiv_seq.sv | 206 ++++++++++++++++++++
 tb/tb_muldiv_seq.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | muldiv_seq: iterative RV32M multiply/divide sequencer (1 bit per cycle). |
// | Optional macro MULDIV_EARLY_OUT_EN: trivial cases skip the iterations.   |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module muldiv_seq #(
  parameter int XLEN  = 32,
  parameter int ITERS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] rs1F,
  input  logic [XLEN-1:0] rs2F,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(ITERS);

  localparam logic [2:0] c_op_mul    = 3'd0;
  localparam logic [2:0] c_op_mulh   = 3'd1;
  localparam logic [2:0] c_op_mulhsu = 3'd2;
  localparam logic [2:0] c_op_mulhu  = 3'd3;
  localparam logic [2:0] c_op_div    = 3'd4;
  localparam logic [2:0] c_op_divu   = 3'd5;
  localparam logic [2:0] c_op_rem    = 3'd6;
  localparam logic [2:0] c_op_remu   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_op;
  logic [XLEN-1:0] r_m;
  logic [XLEN-1:0] r_hi;
  logic [XLEN-1:0] r_lo;
  logic [XLEN-1:0] r_rs1;
  logic [XLEN-1:0] r_result;
  logic            r_neg;
  logic            r_rneg;
  logic            r_divz;
  logic            r_ovf;
  logic            r_mzero;
  logic            r_done;

  logic            w_is_div;
  logic            w_sgn_a;
  logic            w_sgn_b;
  logic            w_aneg;
  logic            w_bneg;
  logic [XLEN-1:0] w_amag;
  logic [XLEN-1:0] w_bmag;
  logic            w_divz;
  logic            w_ovf;
  logic            w_mzero;
  logic            w_skip;

  assign w_is_div = op[2];
  assign w_sgn_a  = (op == c_op_mulh) | (op == c_op_mulhsu) | (op == c_op_div) | (op == c_op_rem);
  assign w_sgn_b  = (op == c_op_mulh) | (op == c_op_div) | (op == c_op_rem);
  assign w_aneg   = w_sgn_a & rs1F[XLEN-1];
  assign w_bneg   = w_sgn_b & rs2F[XLEN-1];
  assign w_amag   = w_aneg ? ('0 - rs1F) : rs1F;
  assign w_bmag   = w_bneg ? ('0 - rs2F) : rs2F;
  assign w_divz   = w_is_div & (rs2F == '0);
  assign w_ovf    = ((op == c_op_div) | (op == c_op_rem)) &
                    (rs1F == {1'b1, {(XLEN-1){1'b0}}}) & (&rs2F);
  assign w_mzero  = ~w_is_div & ((rs1F == '0) | (rs2F == '0));

`ifdef MULDIV_EARLY_OUT_EN
  assign w_skip = w_divz | w_ovf | w_mzero;
`else
  assign w_skip = 1'b0;
`endif

  // Shared adder/subtractor: divide subtracts divisor from the shifted remainder,
  // multiply adds the multiplicand into the accumulator high half.
  logic            w_rdiv;
  logic [XLEN:0]   w_trial;
  logic [XLEN+1:0] w_addsub;
  logic [XLEN:0]   w_mul_sum;
  logic [XLEN-1:0] w_hi_nx;
  logic [XLEN-1:0] w_lo_nx;

  assign w_rdiv    = r_op[2];
  assign w_trial   = {r_hi, r_lo[XLEN-1]};
  assign w_addsub  = w_rdiv ? ({1'b0, w_trial} - {2'b00, r_m}) : ({2'b00, r_hi} + {2'b00, r_m});
  assign w_mul_sum = r_lo[0] ? w_addsub[XLEN:0] : {1'b0, r_hi};

  always_comb begin
    w_hi_nx = r_hi;
    w_lo_nx = r_lo;
    if (w_rdiv) begin
      if (!w_addsub[XLEN+1]) begin
        w_hi_nx = w_addsub[XLEN-1:0];
        w_lo_nx = {r_lo[XLEN-2:0], 1'b1};
      end else begin
        w_hi_nx = w_trial[XLEN-1:0];
        w_lo_nx = {r_lo[XLEN-2:0], 1'b0};
      end
    end else begin
      w_hi_nx = w_mul_sum[XLEN:1];
      w_lo_nx = {w_mul_sum[0], r_lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] w_prod;
  logic [2*XLEN-1:0] w_prod_s;
  logic [XLEN-1:0]   w_quo;
  logic [XLEN-1:0]   w_rem;
  logic [XLEN-1:0]   w_fin;

  assign w_prod   = {r_hi, r_lo};
  assign w_prod_s = r_neg ? ('0 - w_prod) : w_prod;
  assign w_quo    = r_neg ? ('0 - r_lo) : r_lo;
  assign w_rem    = r_rneg ? ('0 - r_hi) : r_hi;

  always_comb begin
    w_fin = '0;
    case (r_op)
      c_op_mul:    w_fin = r_mzero ? '0 : w_prod_s[XLEN-1:0];
      c_op_mulh,
      c_op_mulhsu,
      c_op_mulhu:  w_fin = r_mzero ? '0 : w_prod_s[2*XLEN-1:XLEN];
      c_op_div:    w_fin = r_divz ? '1 : (r_ovf ? {1'b1, {(XLEN-1){1'b0}}} : w_quo);
      c_op_divu:   w_fin = r_divz ? '1 : r_lo;
      c_op_rem:    w_fin = r_divz ? r_rs1 : (r_ovf ? '0 : w_rem);
      c_op_remu:   w_fin = r_divz ? r_rs1 : r_hi;
      default:     w_fin = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_m      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_rs1    <= '0;
      r_result <= '0;
      r_neg    <= 1'b0;
      r_rneg   <= 1'b0;
      r_divz   <= 1'b0;
      r_ovf    <= 1'b0;
      r_mzero  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start && !flush) begin
            r_op    <= op;
            r_rs1   <= rs1F;
            r_m     <= w_is_div ? w_bmag : w_amag;
            r_lo    <= w_is_div ? w_amag : w_bmag;
            r_hi    <= '0;
            r_neg   <= w_aneg ^ w_bneg;
            r_rneg  <= w_aneg;
            r_divz  <= w_divz;
            r_ovf   <= w_ovf;
            r_mzero <= w_mzero;
            r_cnt   <= '0;
            r_state <= w_skip ? S_FIN : S_CALC;
          end
        end
        S_CALC: begin
          if (flush) begin
            r_state <= S_IDLE;
          end else begin
            r_hi  <= w_hi_nx;
            r_lo  <= w_lo_nx;
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(ITERS-1)) r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
          if (!flush) begin
            r_result <= w_fin;
            r_done   <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign stall  = (start & (r_state == S_IDLE)) | (r_state == S_CALC) | (r_state == S_FIN);
  assign busy   = (r_state != S_IDLE);
  assign done   = r_done;
  assign result = r_result;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_seq.sv
`default_nettype none
// tb_muldiv_seq: directed + random RV32M ops against an arithmetic reference model.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] rs1F;
  logic [31:0] rs2F;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  muldiv_seq #(.XLEN(32), .ITERS(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .rs1F   (rs1F),
    .rs2F   (rs2F),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] last_exp = 32'h0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, p;
    int     ia, ib;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'h0, a};
    ub = {32'h0, b};
    ia = $signed(a);
    ib = $signed(b);
    p  = 0;
    case (o)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return ia / ib;
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return ia % ib;
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2])
      return (b == 0) || ((o == 3'd4 || o == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    return (a == 0) || (b == 0);
  endfunction

  // Issue one op in the next cycle (cycle 0) and follow it until done or a cycle budget expires.
  task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input bit hold_start);
    int exp_cyc;
    int done_cyc;
    int stall_low;
    exp_cyc   = (EARLY && is_special(o, a, b)) ? 2 : 34;
    done_cyc  = -1;
    stall_low = 0;
    tick();
    start = 1'b1; op = o; rs1F = a; rs2F = b;
    #2;
    if (!stall) stall_low++;
    for (int c = 1; c <= 60 && done_cyc < 0; c++) begin
      tick();
      if (!hold_start || !busy) start = 1'b0;
      #2;
      if (done) done_cyc = c;
      else if (!stall) stall_low++;
    end
    start = 1'b0;
    check_eq($sformatf("latency op%0d", o), done_cyc, exp_cyc);
    check_eq($sformatf("result op%0d a=%08h b=%08h", o, a, b), result, exp);
    check_eq("stall_in_done_cycle", {31'h0, stall}, 32'h0);
    check_eq("stall_low_before_done", stall_low, 0);
    tick();
    #2;
    check_eq("done_single_cycle", {31'h0, done}, 32'h0);
    check_eq("result_held", result, exp);
    last_exp = exp;
  endtask

  logic [2:0]  d_op  [12] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd5, 3'd6, 3'd4, 3'd6};
  logic [31:0] d_a   [12] = '{32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                              32'd100, 32'd100, 32'h1234, 32'h1234, 32'h8000_0000, 32'h8000_0000};
  logic [31:0] d_b   [12] = '{32'd6, 32'd2, 32'd2, 32'd2, 32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
                              32'hFFFF_FFFF, 32'hFFFF_FFFF};
  logic [31:0] d_exp [12] = '{32'h2A, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF,
                              32'd14, 32'd2, 32'hFFFF_FFFF, 32'h1234, 32'h8000_0000, 32'h0};

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int          saw_done;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    int          sel;

    rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'd0; rs1F = 32'h0; rs2F = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check_eq("reset_done", {31'h0, done}, 32'h0);
    check_eq("reset_busy", {31'h0, busy}, 32'h0);
    check_eq("reset_stall", {31'h0, stall}, 32'h0);
    check_eq("reset_result", result, 32'h0);

    for (int i = 0; i < 12; i++) run_op(d_op[i], d_a[i], d_b[i], d_exp[i], 1'b0);

    for (int i = 0; i < 50; i++) begin
      ro  = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) ra = 32'h0;
      else if (sel == 1) rb = 32'h0;
      else if (sel == 2) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 3) rb = $urandom_range(1, 15);
      run_op(ro, ra, rb, ref_model(ro, ra, rb), 1'b0);
    end

    // Flush a DIV in cycle 10; a fresh op then starts in cycle 12.
    saw_done = 0;
    tick();
    start = 1'b1; op = 3'd4; rs1F = 32'd1000; rs2F = 32'd3;
    #2;
    for (int c = 1; c <= 10; c++) begin
      tick();
      start = 1'b0;
      if (c == 10) flush = 1'b1;
      #2;
      if (done) saw_done++;
    end
    tick();
    flush = 1'b0;
    #2;
    if (done) saw_done++;
    check_eq("flush_busy", {31'h0, busy}, 32'h0);
    check_eq("flush_stall", {31'h0, stall}, 32'h0);
    check_eq("flush_no_done", saw_done, 0);
    check_eq("flush_result_kept", result, last_exp);
    run_op(3'd5, 32'd1000, 32'd3, 32'd333, 1'b0);

    // Reset asserted in cycle 20 of a MUL.
    saw_done = 0;
    tick();
    start = 1'b1; op = 3'd0; rs1F = 32'd12345; rs2F = 32'd678;
    #2;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
      if (c == 20) rst = 1'b1;
      #2;
      if (done) saw_done++;
    end
    tick();
    rst = 1'b0;
    #2;
    check_eq("rst_mid_done", {31'h0, done}, 32'h0);
    check_eq("rst_mid_busy", {31'h0, busy}, 32'h0);
    check_eq("rst_mid_result", result, 32'h0);
    check_eq("rst_mid_no_done", saw_done, 0);
    last_exp = 32'h0;

    // Start held high throughout CALC: exactly one completion.
    run_op(3'd0, 32'd300, 32'd5, 32'd1500, 1'b1);
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      #2;
      if (done) saw_done++;
    end
    check_eq("held_start_single_done", saw_done, 0);
    check_eq("held_start_idle", {31'h0, busy}, 32'h0);

    // Flush and start together in IDLE: nothing is accepted.
    tick();
    start = 1'b1; flush = 1'b1; op = 3'd0; rs1F = 32'd3; rs2F = 32'd3;
    #2;
    tick();
    start = 1'b0; flush = 1'b0;
    #2;
    check_eq("flush_start_busy", {31'h0, busy}, 32'h0);
    saw_done = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      #2;
      if (done) saw_done++;
    end
    check_eq("flush_start_no_done", saw_done, 0);
    check_eq("flush_start_result", result, last_exp);

    run_op(3'd6, 32'hFFFF_FF00, 32'd7, ref_model(3'd6, 32'hFFFF_FF00, 32'd7), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
